vme_cmd_sequencer: RTL and testbench

Synthesizable, parametrised VME command sequencer. It holds a loadable table of up to DEPTH VME read, write and read-compare commands and replays them through the VME command/data register handshake. Each read result is captured and optionally compared against a masked expected value, and errors and timeouts are counted. It sits between the slow-control/test logic and the VME master register interface, and replaces file-driven command injection with an in-fabric, repeatable sequence.

---
 rtl/vme_cmd_sequencer.sv | 254 +++++++++++++++++++++++++
 tb/tb_vme_cmd_sequencer.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vme_cmd_sequencer.sv
// vme_cmd_sequencer: replays a loadable table of VME write / read /
// read-compare commands through the master's command/data register
// handshake. It captures every result, optionally compares it against a
// masked expected value, and counts mismatches and timeouts.
module vme_cmd_sequencer #(
  parameter int          DEPTH   = 64,
  parameter int          ADDR_W  = 6,
  parameter int          DATA_W  = 16,
  parameter logic [31:0] MASK    = 32'h00a80000,
  parameter int          TO_W    = 8,
  parameter int          TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [1:0]        load_op,
  input  logic [15:0]       load_adr,
  input  logic [DATA_W-1:0] load_dat,
  input  logic [DATA_W-1:0] load_msk,
  input  logic [ADDR_W:0]   n_cmds,
  input  logic              start,
  input  logic              vme_cmd_rd,
  input  logic              vme_dat_wr,
  input  logic [31:0]       vme_dat_reg_out,
  output logic [31:0]       vme_cmd_reg,
  output logic [31:0]       vme_dat_reg_in,
  output logic              cmd_strobe,
  output logic              busy,
  output logic              done,
  output logic              res_valid,
  output logic [ADDR_W-1:0] res_idx,
  output logic [DATA_W-1:0] res_data,
  output logic              res_mismatch,
  output logic [15:0]       err_cnt,
  output logic              timeout
);

  // Entry layout, MSB first: {op[1:0], adr[15:0], dat[DATA_W-1:0], msk[DATA_W-1:0]}
  localparam int ENT_W = 2 + 16 + 2 * DATA_W;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_RDCMP = 2'b11;

  localparam logic [ADDR_W:0] DEPTH_N = (ADDR_W + 1)'(DEPTH);
  localparam logic [TO_W-1:0] TO_LIM  = TO_W'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  // Command table; contents are deliberately not reset
  logic [ENT_W-1:0] mem [DEPTH];
  logic [ENT_W-1:0] ent_reg;

  logic [ADDR_W-1:0] idx_reg;
  logic [ADDR_W-1:0] last_idx_reg;
  logic [TO_W-1:0]   to_cnt_reg;

  // Decoded fields of the entry currently being executed
  logic [1:0]        ent_op;
  logic [15:0]       ent_adr;
  logic [DATA_W-1:0] ent_dat;
  logic [DATA_W-1:0] ent_msk;

  assign ent_op  = ent_reg[ENT_W-1 -: 2];
  assign ent_adr = ent_reg[2*DATA_W +: 16];
  assign ent_dat = ent_reg[DATA_W +: DATA_W];
  assign ent_msk = ent_reg[0 +: DATA_W];

  // Control strobes produced by the output decoder
  logic start_ok;
  logic table_we;
  logic issue_fire;
  logic wait_ack;
  logic wait_abort;
  logic at_last;

  // Datapath helpers
  logic [DATA_W-1:0] rdata;
  logic              cmp_mis;
  logic              err_inc;
  logic [31:0]       cmd_word;
  logic [31:0]       wdata_word;
  logic [ADDR_W:0]   n_eff;
  logic [ADDR_W:0]   n_last_full;

  // Only the low DATA_W bits of the master's read data carry information
  logic unused_ok;
  assign unused_ok = ^vme_dat_reg_out;

  assign rdata   = vme_dat_reg_out[DATA_W-1:0];
  assign at_last = (idx_reg == last_idx_reg);
  assign cmp_mis = (ent_op == OP_RDCMP) && (((rdata ^ ent_dat) & ent_msk) != '0);
  assign err_inc = (wait_ack && cmp_mis) || wait_abort;

  // Requests for more entries than the table holds run the whole table
  assign n_eff       = (n_cmds > DEPTH_N) ? DEPTH_N : n_cmds;
  assign n_last_full = n_eff - 1'b1;

  // Build the command word and zero-extended write data for the current entry
  always_comb begin
    cmd_word   = MASK | {6'b0, ent_op[1], ~ent_op[1], 8'h00, ent_adr};
    wdata_word = '0;
    if (ent_op == OP_WRITE) begin
      wdata_word[DATA_W-1:0] = ent_dat;
    end
  end

  // Table write port (idle only) and registered read of the current entry
  always_ff @(posedge clk) begin
    if (table_we) begin
      mem[load_addr] <= {load_op, load_adr, load_dat, load_msk};
    end
    ent_reg <= mem[idx_reg];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state decode
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          state_next = (n_cmds == '0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_next = S_ISSUE;
      S_ISSUE: begin
        if (ent_op == OP_NOP) begin
          state_next = S_NEXT;
        end else if (vme_cmd_rd) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (vme_dat_wr) begin
          state_next = S_NEXT;
        end else if (to_cnt_reg == TO_LIM) begin
          state_next = S_DONE;
        end
      end
      S_NEXT:  state_next = at_last ? S_DONE : S_FETCH;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // FSM output decode: busy flag and the per-state control strobes
  always_comb begin
    busy       = (state_reg != S_IDLE);
    start_ok   = 1'b0;
    table_we   = 1'b0;
    issue_fire = 1'b0;
    wait_ack   = 1'b0;
    wait_abort = 1'b0;
    case (state_reg)
      S_IDLE: begin
        start_ok = start;
        table_we = load_en;
      end
      S_ISSUE: begin
        issue_fire = (ent_op != OP_NOP) && vme_cmd_rd;
      end
      S_WAIT: begin
        // A completion in the expiry cycle takes priority over the abort
        wait_ack   = vme_dat_wr;
        wait_abort = !vme_dat_wr && (to_cnt_reg == TO_LIM);
      end
      default: begin
      end
    endcase
  end

  // Sequencing index, timeout counter, master registers and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_reg        <= '0;
      last_idx_reg   <= '0;
      to_cnt_reg     <= '0;
      vme_cmd_reg    <= MASK;
      vme_dat_reg_in <= '0;
      cmd_strobe     <= 1'b0;
      done           <= 1'b0;
      res_valid      <= 1'b0;
      res_idx        <= '0;
      res_data       <= '0;
      res_mismatch   <= 1'b0;
      err_cnt        <= '0;
      timeout        <= 1'b0;
    end else begin
      cmd_strobe   <= issue_fire;
      res_valid    <= wait_ack;
      res_mismatch <= wait_ack && cmp_mis;
      done         <= (state_reg == S_DONE);

      if (start_ok) begin
        timeout <= 1'b0;
        if (n_cmds != '0) begin
          idx_reg      <= '0;
          err_cnt      <= '0;
          last_idx_reg <= n_last_full[ADDR_W-1:0];
        end
      end

      if (issue_fire) begin
        vme_cmd_reg    <= cmd_word;
        vme_dat_reg_in <= wdata_word;
        to_cnt_reg     <= '0;
      end else if (state_reg == S_WAIT) begin
        if (wait_ack || wait_abort) begin
          vme_cmd_reg    <= MASK;
          vme_dat_reg_in <= '0;
        end else begin
          to_cnt_reg <= to_cnt_reg + 1'b1;
        end
      end

      if (wait_ack) begin
        res_idx  <= idx_reg;
        res_data <= ent_op[1] ? rdata : ent_dat;
      end

      if (wait_abort) begin
        timeout <= 1'b1;
      end

      if (err_inc && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 1'b1;
      end

      if ((state_reg == S_NEXT) && !at_last) begin
        idx_reg <= idx_reg + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vme_cmd_sequencer.sv
// Directed bench for vme_cmd_sequencer: table of single-command vectors
// followed by hand-written multi-cycle sequences (NOP skip, stalled issue,
// timeout abort, empty run, busy lockout, reset mid-command).
module tb_vme_cmd_sequencer;

  localparam logic [31:0] MASK = 32'h00a80000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_en;
  logic [5:0]  load_addr;
  logic [1:0]  load_op;
  logic [15:0] load_adr;
  logic [15:0] load_dat;
  logic [15:0] load_msk;
  logic [6:0]  n_cmds;
  logic        start;
  logic        vme_cmd_rd;
  logic        vme_dat_wr;
  logic [31:0] vme_dat_reg_out;
  logic [31:0] vme_cmd_reg;
  logic [31:0] vme_dat_reg_in;
  logic        cmd_strobe;
  logic        busy;
  logic        done;
  logic        res_valid;
  logic [5:0]  res_idx;
  logic [15:0] res_data;
  logic        res_mismatch;
  logic [15:0] err_cnt;
  logic        timeout;

  vme_cmd_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .load_en(load_en), .load_addr(load_addr), .load_op(load_op),
    .load_adr(load_adr), .load_dat(load_dat), .load_msk(load_msk),
    .n_cmds(n_cmds), .start(start),
    .vme_cmd_rd(vme_cmd_rd), .vme_dat_wr(vme_dat_wr),
    .vme_dat_reg_out(vme_dat_reg_out),
    .vme_cmd_reg(vme_cmd_reg), .vme_dat_reg_in(vme_dat_reg_in),
    .cmd_strobe(cmd_strobe), .busy(busy), .done(done),
    .res_valid(res_valid), .res_idx(res_idx), .res_data(res_data),
    .res_mismatch(res_mismatch), .err_cnt(err_cnt), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_mis = 0;

  // Master model controls
  logic        m_en = 1'b0;
  int          m_lat = 0;
  logic [15:0] m_rdata = '0;

  // Monitor state
  int          n_strobe = 0;
  int          n_done = 0;
  int          strobe_cyc = 0;
  int          done_cyc = 0;
  int          t_start = 0;
  logic [31:0] mon_cmd = '0;
  logic [31:0] mon_din = '0;
  logic [15:0] mon_res = '0;
  logic        mon_mis = 1'b0;
  logic [5:0]  res_q[$];

  typedef struct {
    logic [1:0]  op;
    logic [15:0] adr;
    logic [15:0] dat;
    logic [15:0] msk;
    logic [15:0] rdata;
    int          lat;
    logic [31:0] exp_cmd;
    logic [31:0] exp_din;
    logic [15:0] exp_res;
    logic        exp_mis;
    logic [15:0] exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Master: answers each strobe with vme_dat_wr m_lat cycles later
  initial begin
    int cnt;
    logic pend;
    cnt = 0;
    pend = 1'b0;
    vme_dat_wr = 1'b0;
    vme_dat_reg_out = '0;
    forever begin
      @(negedge clk);
      vme_dat_wr = 1'b0;
      if (m_en && cmd_strobe) begin
        pend = 1'b1;
        cnt = m_lat;
      end
      if (pend) begin
        if (cnt == 0) begin
          vme_dat_wr = 1'b1;
          vme_dat_reg_out = {16'hDEAD, m_rdata};
          pend = 1'b0;
        end else begin
          cnt--;
        end
      end
    end
  end

  // Monitor: records strobes, results and done pulses
  initial begin
    forever begin
      @(negedge clk);
      if (cmd_strobe) begin
        n_strobe++;
        strobe_cyc = cyc;
        mon_cmd = vme_cmd_reg;
        mon_din = vme_dat_reg_in;
      end
      if (res_valid) begin
        res_q.push_back(res_idx);
        mon_res = res_data;
        mon_mis = res_mismatch;
      end
      if (done) begin
        n_done++;
        done_cyc = cyc;
      end
    end
  end

  task automatic load_entry(input logic [5:0] a, input logic [1:0] op, input logic [15:0] adr,
                            input logic [15:0] dat, input logic [15:0] msk);
    tick();
    load_en = 1'b1;
    load_addr = a;
    load_op = op;
    load_adr = adr;
    load_dat = dat;
    load_msk = msk;
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    tick();
    start = 1'b1;
    t_start = cyc;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int max_cyc);
    int base;
    int k;
    base = n_done;
    k = 0;
    while (n_done == base && k < max_cyc) begin
      tick();
      k++;
    end
    if (n_done == base) begin
      n_vec++;
      n_mis++;
      $display("FAIL %s: no done pulse within %0d cycles", name, max_cyc);
    end
  endtask

  initial begin
    int s0;
    int d0;
    rst_n = 1'b0;
    load_en = 1'b0;
    load_addr = '0;
    load_op = '0;
    load_adr = '0;
    load_dat = '0;
    load_msk = '0;
    n_cmds = '0;
    start = 1'b0;
    vme_cmd_rd = 1'b1;

    vecs[0] = '{2'b01, 16'h0070, 16'h1234, 16'h0000, 16'h0000, 3, 32'h01A80070, 32'h00001234, 16'h1234, 1'b0, 16'd0};
    vecs[1] = '{2'b11, 16'h0004, 16'hABCD, 16'hFF00, 16'hAB00, 2, 32'h02A80004, 32'h00000000, 16'hAB00, 1'b0, 16'd0};
    vecs[2] = '{2'b11, 16'h0004, 16'hABCD, 16'hFF00, 16'hAC00, 3, 32'h02A80004, 32'h00000000, 16'hAC00, 1'b1, 16'd1};
    vecs[3] = '{2'b10, 16'h1234, 16'hFFFF, 16'hFFFF, 16'h5A5A, 0, 32'h02A81234, 32'h00000000, 16'h5A5A, 1'b0, 16'd0};
    vecs[4] = '{2'b11, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF, 1, 32'h02A8FFFF, 32'h00000000, 16'hFFFF, 1'b0, 16'd0};
    vecs[5] = '{2'b01, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h0000, 5, 32'h01A80000, 32'h0000FFFF, 16'hFFFF, 1'b0, 16'd0};
    vecs[6] = '{2'b11, 16'h00C3, 16'h00FF, 16'h0001, 16'h00FE, 2, 32'h02A800C3, 32'h00000000, 16'h00FE, 1'b1, 16'd1};

    // Reset state
    repeat (3) tick();
    check("rst_cmd_reg", vme_cmd_reg, MASK);
    check("rst_dat_in", vme_dat_reg_in, 32'h0);
    check("rst_err_cnt", 32'(err_cnt), 32'h0);
    check("rst_flags", {26'h0, busy, done, cmd_strobe, res_valid, res_mismatch, timeout}, 32'h0);
    rst_n = 1'b1;
    tick();

    // Single-command vectors
    m_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      load_entry(6'd0, vecs[i].op, vecs[i].adr, vecs[i].dat, vecs[i].msk);
      n_cmds = 7'd1;
      m_lat = vecs[i].lat;
      m_rdata = vecs[i].rdata;
      res_q.delete();
      s0 = n_strobe;
      pulse_start();
      check($sformatf("v%0d_busy", i), 32'(busy), 32'h1);
      wait_done($sformatf("v%0d_done", i), 100);
      check($sformatf("v%0d_strobes", i), 32'(n_strobe - s0), 32'd1);
      check($sformatf("v%0d_start_lat", i), 32'(strobe_cyc - t_start), 32'd3);
      check($sformatf("v%0d_cmd", i), mon_cmd, vecs[i].exp_cmd);
      check($sformatf("v%0d_din", i), mon_din, vecs[i].exp_din);
      check($sformatf("v%0d_nres", i), 32'(res_q.size()), 32'd1);
      if (res_q.size() == 1) check($sformatf("v%0d_res_idx", i), 32'(res_q[0]), 32'd0);
      check($sformatf("v%0d_res_data", i), 32'(mon_res), 32'(vecs[i].exp_res));
      check($sformatf("v%0d_mismatch", i), 32'(mon_mis), 32'(vecs[i].exp_mis));
      check($sformatf("v%0d_err_cnt", i), 32'(err_cnt), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_done_lat", i), 32'(done_cyc - strobe_cyc), 32'(vecs[i].lat + 3));
      check($sformatf("v%0d_busy_end", i), 32'(busy), 32'h0);
      check($sformatf("v%0d_cmd_idle", i), vme_cmd_reg, MASK);
      $display("vec %0d op=%b adr=%h res=%h mis=%0d err=%0d", i, vecs[i].op, vecs[i].adr, mon_res, mon_mis, err_cnt);
    end

    // Four entries with a NOP at index 2, issue stalled by vme_cmd_rd low
    load_entry(6'd0, 2'b01, 16'h0100, 16'h0001, 16'h0000);
    load_entry(6'd1, 2'b10, 16'h0101, 16'h0000, 16'h0000);
    load_entry(6'd2, 2'b00, 16'h0102, 16'h0000, 16'h0000);
    load_entry(6'd3, 2'b11, 16'h0103, 16'h0000, 16'h0000);
    n_cmds = 7'd4;
    m_lat = 1;
    m_rdata = 16'h0F0F;
    res_q.delete();
    vme_cmd_rd = 1'b0;
    s0 = n_strobe;
    pulse_start();
    repeat (10) tick();
    check("nop_no_early_strobe", 32'(n_strobe - s0), 32'd0);
    vme_cmd_rd = 1'b1;
    wait_done("nop_done", 200);
    check("nop_strobes", 32'(n_strobe - s0), 32'd3);
    check("nop_nres", 32'(res_q.size()), 32'd3);
    if (res_q.size() == 3) begin
      check("nop_idx0", 32'(res_q[0]), 32'd0);
      check("nop_idx1", 32'(res_q[1]), 32'd1);
      check("nop_idx2", 32'(res_q[2]), 32'd3);
    end
    check("nop_last_cmd", mon_cmd, 32'h02A80103);
    $display("seq nop: strobes=%0d results=%0d", n_strobe - s0, res_q.size());

    // Timeout abort: master silent
    load_entry(6'd0, 2'b10, 16'h0042, 16'h0000, 16'h0000);
    n_cmds = 7'd1;
    m_en = 1'b0;
    res_q.delete();
    pulse_start();
    wait_done("to_done", 600);
    check("to_timeout", 32'(timeout), 32'h1);
    check("to_err_cnt", 32'(err_cnt), 32'd1);
    check("to_done_lat", 32'(done_cyc - strobe_cyc), 32'd257);
    check("to_no_result", 32'(res_q.size()), 32'd0);
    check("to_cmd_idle", vme_cmd_reg, MASK);
    $display("seq timeout: timeout=%0d err=%0d", timeout, err_cnt);

    // Next start clears timeout and err_cnt
    m_en = 1'b1;
    m_lat = 1;
    pulse_start();
    check("to_clr_timeout", 32'(timeout), 32'h0);
    check("to_clr_err", 32'(err_cnt), 32'h0);
    wait_done("to_clr_done", 100);
    check("to_clr_err_end", 32'(err_cnt), 32'h0);
    $display("seq timeout clear: timeout=%0d err=%0d", timeout, err_cnt);

    // Empty run
    n_cmds = 7'd0;
    s0 = n_strobe;
    pulse_start();
    wait_done("empty_done", 20);
    check("empty_done_lat", 32'(done_cyc - t_start), 32'd2);
    check("empty_strobes", 32'(n_strobe - s0), 32'd0);
    $display("seq empty: done after %0d cycles", done_cyc - t_start);

    // load_en and start while busy are ignored
    load_entry(6'd0, 2'b01, 16'h0011, 16'h0022, 16'h0000);
    n_cmds = 7'd1;
    vme_cmd_rd = 1'b0;
    s0 = n_strobe;
    d0 = n_done;
    pulse_start();
    repeat (3) tick();
    load_entry(6'd0, 2'b10, 16'h0099, 16'h0000, 16'h0000);
    pulse_start();
    vme_cmd_rd = 1'b1;
    wait_done("busy_done", 100);
    repeat (12) tick();
    check("busy_cmd", mon_cmd, 32'h01A80011);
    check("busy_strobes", 32'(n_strobe - s0), 32'd1);
    check("busy_dones", 32'(n_done - d0), 32'd1);
    pulse_start();
    wait_done("busy_rerun_done", 100);
    check("busy_table_kept", mon_cmd, 32'h01A80011);
    $display("seq busy lockout: cmd=%h", mon_cmd);

    // Reset asserted during WAIT
    load_entry(6'd0, 2'b10, 16'h0200, 16'h0000, 16'h0000);
    load_entry(6'd1, 2'b01, 16'h0201, 16'h0055, 16'h0000);
    n_cmds = 7'd2;
    m_en = 1'b0;
    s0 = n_strobe;
    pulse_start();
    for (int k = 0; k < 20 && n_strobe == s0; k++) tick();
    check("rstw_strobe_seen", 32'(n_strobe - s0), 32'd1);
    repeat (3) tick();
    check("rstw_cmd_before", vme_cmd_reg, 32'h02A80200);
    d0 = n_done;
    rst_n = 1'b0;
    #1;
    check("rstw_cmd_reg", vme_cmd_reg, MASK);
    check("rstw_busy", 32'(busy), 32'h0);
    check("rstw_dat_in", vme_dat_reg_in, 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check("rstw_no_done", 32'(n_done - d0), 32'd0);
    m_en = 1'b1;
    m_lat = 2;
    res_q.delete();
    s0 = n_strobe;
    pulse_start();
    wait_done("rstw_replay_done", 200);
    check("rstw_replay_strobes", 32'(n_strobe - s0), 32'd2);
    check("rstw_replay_nres", 32'(res_q.size()), 32'd2);
    if (res_q.size() == 2) begin
      check("rstw_replay_idx0", 32'(res_q[0]), 32'd0);
      check("rstw_replay_idx1", 32'(res_q[1]), 32'd1);
    end
    check("rstw_replay_cmd", mon_cmd, 32'h01A80201);
    $display("seq reset in wait: replay results=%0d", res_q.size());

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
